val2_iter_shifter: RTL and testbench

- Multi-cycle, parametrised Operand2 (Val2) generator for the EXE stage.
- Covers memory offset, rotated 8-bit immediate, and register shifts LSL/LSR/ASR/ROR/RRX.
- Adds ARM-correct zero-amount encodings, true arithmetic right shift and a shifter carry-out.
- Shifts STEP bits per cycle behind a valid/ready handshake so the hazard unit can stall on it.

---
 rtl/val2_iter_shifter.sv | 173 +++++++++++++++++
 tb/tb_val2_iter_shifter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/val2_iter_shifter.sv
// Iterative Val2 (Operand2) generator: MEM offset, rotated imm8, LSL/LSR/ASR/ROR/RRX.
// Optional macro VAL2_BACK_TO_BACK_EN lets a new request be accepted while DONE drains.
module val2_iter_shifter #(
  parameter int DATA_W = 32,
  parameter int STEP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rm,
  input  logic [11:0]       shift_operand,
  input  logic              immediate,
  input  logic              is_mem_instruction,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              busy
);

  localparam int CW = 8;
  localparam logic [CW-1:0] STEP_C = CW'(STEP);
  localparam logic [CW-1:0] W_C    = CW'(DATA_W);
  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              fill_q, fill_d;

  logic              accept;
  state_e            ld_state;
  logic [DATA_W-1:0] ld_val;
  logic              ld_carry;
  logic [CW-1:0]     ld_cnt;
  logic [1:0]        ld_op;
  logic              ld_fill;
  logic [4:0]        amt;
  logic [1:0]        typ;

  logic [CW-1:0]     k;
  logic [DATA_W:0]   lsl_x;
  logic [DATA_W-1:0] rsh_v;
  logic [DATA_W-1:0] ror_v;
  logic              rsh_c;
  logic [DATA_W-1:0] step_v;
  logic              step_c;

`ifdef VAL2_BACK_TO_BACK_EN
  assign in_ready = (state_q == S_IDLE) ||
                    ((state_q == S_DONE) && out_ready);
`else
  assign in_ready = (state_q == S_IDLE);
`endif

  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_SHIFT);
  assign result    = val_q;
  assign carry_out = carry_q;

  assign amt = shift_operand[11:7];
  assign typ = shift_operand[6:5];

  // Decode a request into the initial datapath value and remaining amount
  always_comb begin
    ld_val   = rm;
    ld_carry = carry_in;
    ld_cnt   = '0;
    ld_op    = typ;
    ld_fill  = 1'b0;
    if (is_mem_instruction) begin
      ld_val = {{(DATA_W-12){shift_operand[11]}}, shift_operand};
    end else if (immediate) begin
      ld_val = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
      ld_op  = 2'b11;
      ld_cnt = {{(CW-5){1'b0}}, shift_operand[11:8], 1'b0};
    end else if (typ == 2'b11 && amt == 5'd0) begin
      ld_val   = {carry_in, rm[DATA_W-1:1]};
      ld_carry = rm[0];
    end else if (typ != 2'b00 && typ != 2'b11 && amt == 5'd0) begin
      ld_cnt  = CW'(32);
      ld_fill = (typ == 2'b10) && rm[DATA_W-1];
    end else begin
      ld_cnt  = {{(CW-5){1'b0}}, amt};
      ld_fill = (typ == 2'b10) && rm[DATA_W-1];
    end
    ld_state = (ld_cnt == '0) ? S_DONE : S_SHIFT;
  end

  // One iteration: shift by min(STEP, remaining)
  always_comb begin
    k     = (cnt_q < STEP_C) ? cnt_q : STEP_C;
    lsl_x = {1'b0, val_q} << k;
    rsh_v = (val_q >> k) |
            ({DATA_W{fill_q}} & ~({DATA_W{1'b1}} >> k));
    rsh_c = |(val_q & (ONE << (k - CW'(1))));
    ror_v = (val_q >> k) | (val_q << (W_C - k));
    unique case (op_q)
      2'b00: begin
        step_v = lsl_x[DATA_W-1:0];
        step_c = lsl_x[DATA_W];
      end
      2'b11: begin
        step_v = ror_v;
        step_c = ror_v[DATA_W-1];
      end
      default: begin
        step_v = rsh_v;
        step_c = rsh_c;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    fill_d  = fill_q;
    if (accept) begin
      state_d = ld_state;
      val_d   = ld_val;
      carry_d = ld_carry;
      cnt_d   = ld_cnt;
      op_d    = ld_op;
      fill_d  = ld_fill;
    end else begin
      unique case (state_q)
        S_SHIFT: begin
          val_d   = step_v;
          carry_d = step_c;
          cnt_d   = cnt_q - k;
          if (cnt_q == k) state_d = S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: tb/tb_val2_iter_shifter.sv
// Scoreboard bench for val2_iter_shifter: directed plan cases plus random requests.
// Expected values come from a plain-arithmetic Operand2 model.
module tb_val2_iter_shifter;

  localparam int W    = 32;
  localparam int STEP = 2;
`ifdef VAL2_BACK_TO_BACK_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  rm = '0;
  logic [11:0]   shift_operand = '0;
  logic          immediate = 1'b0;
  logic          is_mem_instruction = 1'b0;
  logic          carry_in = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          carry_out;
  logic          busy;

  val2_iter_shifter #(.DATA_W(W), .STEP(STEP)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .rm                 (rm),
    .shift_operand      (shift_operand),
    .immediate          (immediate),
    .is_mem_instruction (is_mem_instruction),
    .carry_in           (carry_in),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .result             (result),
    .carry_out          (carry_out),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        c;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] r, input logic [11:0] op,
                                 input logic im, input logic me, input logic ci);
    exp_t e;
    logic [63:0] x;
    logic [63:0] y;
    logic [31:0] v;
    int a;
    int eff;
    eff = 0;
    if (me) begin
      e.res = {{20{op[11]}}, op};
      e.c   = ci;
    end else if (im) begin
      a = 2 * int'(op[11:8]);
      v = {24'd0, op[7:0]};
      eff = a;
      if (a == 0) begin
        e.res = v;
        e.c   = ci;
      end else begin
        e.res = (v >> a) | (v << (32 - a));
        e.c   = e.res[31];
      end
    end else begin
      a = int'(op[11:7]);
      case (op[6:5])
        2'b00: begin
          if (a == 0) begin
            e.res = r;
            e.c   = ci;
          end else begin
            x = {32'd0, r} << a;
            e.res = x[31:0];
            e.c   = x[32];
            eff = a;
          end
        end
        2'b11: begin
          if (a == 0) begin
            e.res = {ci, r[31:1]};
            e.c   = r[0];
          end else begin
            e.res = (r >> a) | (r << (32 - a));
            e.c   = e.res[31];
            eff = a;
          end
        end
        default: begin
          if (a == 0) a = 32;
          eff = a;
          if (op[6:5] == 2'b10) x = {{32{r[31]}}, r} >> a;
          else x = {32'd0, r} >> a;
          y = {32'd0, r} >> (a - 1);
          e.res = x[31:0];
          e.c   = y[0];
        end
      endcase
    end
    e.lat = 1 + (eff + STEP - 1) / STEP;
    e.acc = 0;
    return e;
  endfunction

  task automatic issue(input logic [31:0] r, input logic [11:0] op,
                       input logic im, input logic me, input logic ci);
    exp_t e;
    int t;
    @(negedge clk);
    rm = r;
    shift_operand = op;
    immediate = im;
    is_mem_instruction = me;
    carry_in = ci;
    in_valid = 1'b1;
    #2;
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
    end else begin
      e = model(r, op, im, me, ci);
      e.acc = cyc + 1;
      q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rdy_mode == 1) out_ready = 1'b0;
      else if (rdy_mode == 2) out_ready = 1'b1;
      else out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    exp_t cur;
    bit seen;
    logic exp_rdy;
    seen = 1'b0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        seen = 1'b0;
        continue;
      end
      exp_rdy = (!out_valid && !busy) || (BTB && out_valid && out_ready);
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (out_valid) begin
        if (!seen) begin
          if (q.size() == 0) begin
            check("unexpected_out_valid", 64'd1, 64'd0);
          end else begin
            cur = q.pop_front();
            check("result", 64'(result), 64'(cur.res));
            check("carry_out", 64'(carry_out), 64'(cur.c));
            check("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
          end
          seen = 1'b1;
        end else begin
          check("hold_result", 64'(result), 64'(cur.res));
          check("hold_carry", 64'(carry_out), 64'(cur.c));
        end
        if (out_ready) seen = 1'b0;
      end
    end
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_carry", 64'(carry_out), 64'd0);

    issue(32'h1234_5678, 12'hFFC, 1'b0, 1'b1, 1'b1);
    issue(32'h0, 12'h4FF, 1'b1, 1'b0, 1'b0);
    issue(32'h8000_0010, 12'h240, 1'b0, 1'b0, 1'b0);
    issue(32'h8000_0010, 12'h040, 1'b0, 1'b0, 1'b0);
    issue(32'h0000_0003, 12'h060, 1'b0, 1'b0, 1'b1);
    issue(32'h0000_0003, 12'h020, 1'b0, 1'b0, 1'b1);
    issue(32'hA5A5_0F0F, 12'h000, 1'b0, 1'b0, 1'b1);
    issue(32'hFFFF_FFFF, 12'h0AB, 1'b1, 1'b0, 1'b1);
    issue(32'h8000_0001, 12'hF80, 1'b0, 1'b0, 1'b0);
    issue(32'h8000_0001, 12'hFE0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 250; i++) begin
      issue($urandom, 12'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), 1'($urandom));
    end
    drain();

    rdy_mode = 1;
    issue(32'h0, 12'hFFC, 1'b0, 1'b1, 1'b0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("hs_out_valid", 64'(out_valid), 64'd1);
    repeat (5) @(negedge clk);
    rdy_mode = 2;
    issue(32'h0, 12'h7F0, 1'b0, 1'b1, 1'b1);
    rdy_mode = 0;
    drain();

    issue($urandom, 12'hF80, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    issue(32'h0, 12'h801, 1'b0, 1'b1, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
